// File: rtl/prog_sequencer.sv
// prog_sequencer: host-side sequencer for the core's reset/done run protocol.
//
// For each of three programs (product, pattern count, min pair distance) it
// preloads operands into data memory while the core is held in reset, releases
// the core, waits for done, re-asserts core reset and reads the result back.
// All three programs run back to back after a single start pulse.
//
// Ports:
//   clk           clock, all state on rising edge
//   reset         asynchronous active-low reset
//   start         one-cycle pulse, begins the sequence when idle
//   core_reset    reset to the core (1 holds it)
//   core_done     done from the core
//   dm_addr       data memory address
//   dm_wr_en      data memory write strobe
//   dm_wr_data    data memory write data
//   dm_rd_data    data memory read data (combinational on dm_addr)
//   busy          sequence in progress
//   result_valid  one-cycle pulse per program result
//   result_prog   program index of the current result
//   result_data   result value
//   all_done      set after program 2 is reported, cleared by start
//   timeout_err   sticky watchdog error
//
// Optional feature: define PROG_SEQ_TIMEOUT_EN to add a WAIT_DONE watchdog
// (TIMEOUT_CYC cycles); a timed-out program reports 16'hDEAD. Without it the
// sequencer waits for done indefinitely and timeout_err is tied low.
module prog_sequencer #(
  parameter logic [7:0]  OP_A        = 8'd5,
  parameter logic [7:0]  OP_B        = 8'd15,
  parameter logic [7:0]  OP_C        = 8'd2,
  parameter logic [7:0]  PATTERN     = 8'h0D,
  parameter logic [7:0]  SEED        = 8'h17
`ifdef PROG_SEQ_TIMEOUT_EN
  ,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        core_reset,
  input  logic        core_done,
  output logic [7:0]  dm_addr,
  output logic        dm_wr_en,
  output logic [7:0]  dm_wr_data,
  input  logic [7:0]  dm_rd_data,
  output logic        busy,
  output logic        result_valid,
  output logic [1:0]  result_prog,
  output logic [15:0] result_data,
  output logic        all_done,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    StIdle, StLoad, StRun, StWaitDone, StHold, StReadHi, StReadLo, StReport, StFinish
  } state_e;

  state_e      state_q;
  logic [1:0]  prog_q;
  logic [6:0]  idx_q;          // index of the next load write
  logic [7:0]  lfsr_q;
  logic        wait_first_q;   // first WAIT_DONE cycle, done is masked
  logic [7:0]  hi_q;
  logic        core_reset_q;
  logic        dm_wr_en_q;
  logic [7:0]  dm_addr_q;
  logic [7:0]  dm_wr_data_q;
  logic        busy_q;
  logic        result_valid_q;
  logic [1:0]  result_prog_q;
  logic [15:0] result_data_q;
  logic        all_done_q;

  logic [7:0]  lfsr_next;
  logic [1:0]  wr_prog;
  logic [6:0]  wr_idx;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_lfsr;
  logic        load_last;
  logic        issue_wr;
  logic        done_seen;
  logic        wd_fire;
  logic        report_dead;
  logic [7:0]  rd_addr_hi;
  logic [7:0]  rd_addr_lo;

  function automatic logic [6:0] load_len(input logic [1:0] p);
    case (p)
      2'd0:    return 7'd3;
      2'd1:    return 7'd65;
      default: return 7'd20;
    endcase
  endfunction

  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Next load write. On entry to LOAD (from IDLE or REPORT) the write is for
  // index 0 of the upcoming program, so outputs are valid in the first LOAD cycle.
  always_comb begin
    wr_prog = prog_q;
    wr_idx  = idx_q;
    if (state_q == StIdle) begin
      wr_prog = 2'd0;
      wr_idx  = '0;
    end else if (state_q == StReport) begin
      wr_prog = prog_q + 2'd1;
      wr_idx  = '0;
    end
    wr_addr = '0;
    wr_data = '0;
    wr_lfsr = 1'b0;
    case (wr_prog)
      2'd0: begin
        wr_addr = 8'd1 + {1'b0, wr_idx};
        wr_data = (wr_idx == 7'd0) ? OP_A : (wr_idx == 7'd1) ? OP_B : OP_C;
      end
      2'd1: begin
        if (wr_idx == 7'd0) begin
          wr_addr = 8'd6;
          wr_data = PATTERN;
        end else begin
          wr_addr = 8'd31 + {1'b0, wr_idx};
          wr_data = lfsr_q;
          wr_lfsr = 1'b1;
        end
      end
      default: begin
        wr_addr = 8'd128 + {1'b0, wr_idx};
        wr_data = lfsr_q;
        wr_lfsr = 1'b1;
      end
    endcase
  end

  assign load_last = (idx_q == load_len(prog_q));
  assign issue_wr  = (state_q == StIdle && start) ||
                     (state_q == StLoad && !load_last) ||
                     (state_q == StReport && prog_q != 2'd2);
  assign done_seen = !wait_first_q && core_done;

  assign rd_addr_hi = (prog_q == 2'd0) ? 8'd4 : (prog_q == 2'd1) ? 8'd7 : 8'd127;
  assign rd_addr_lo = (prog_q == 2'd0) ? 8'd5 : (prog_q == 2'd1) ? 8'd7 : 8'd127;

`ifdef PROG_SEQ_TIMEOUT_EN
  logic [19:0] tmo_cnt_q;
  logic        tmo_hit_q;
  logic        timeout_err_q;
  assign wd_fire     = (tmo_cnt_q + 20'd1 == TIMEOUT_CYC);
  assign report_dead = tmo_hit_q;
  assign timeout_err = timeout_err_q;
`else
  assign wd_fire     = 1'b0;
  assign report_dead = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      prog_q         <= '0;
      idx_q          <= '0;
      lfsr_q         <= SEED;
      wait_first_q   <= 1'b0;
      hi_q           <= '0;
      core_reset_q   <= 1'b1;
      dm_wr_en_q     <= 1'b0;
      dm_addr_q      <= '0;
      dm_wr_data_q   <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_prog_q  <= '0;
      result_data_q  <= '0;
      all_done_q     <= 1'b0;
`ifdef PROG_SEQ_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      tmo_hit_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
`endif
    end else begin
      result_valid_q <= 1'b0;
      if (issue_wr) begin
        dm_wr_en_q   <= 1'b1;
        dm_addr_q    <= wr_addr;
        dm_wr_data_q <= wr_data;
        idx_q        <= wr_idx + 7'd1;
        if (wr_lfsr) lfsr_q <= lfsr_next;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StLoad;
            busy_q     <= 1'b1;
            all_done_q <= 1'b0;
            prog_q     <= '0;
`ifdef PROG_SEQ_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
          end
        end
        StLoad: begin
          if (load_last) begin
            state_q      <= StRun;
            dm_wr_en_q   <= 1'b0;
            core_reset_q <= 1'b0;
`ifdef PROG_SEQ_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
          end
        end
        StRun: begin
          state_q      <= StWaitDone;
          wait_first_q <= 1'b1;
        end
        StWaitDone: begin
          wait_first_q <= 1'b0;
`ifdef PROG_SEQ_TIMEOUT_EN
          tmo_cnt_q    <= tmo_cnt_q + 20'd1;
`endif
          if (done_seen || wd_fire) begin
            state_q      <= StHold;
            core_reset_q <= 1'b1;
`ifdef PROG_SEQ_TIMEOUT_EN
            // A done arriving in the same cycle as the watchdog wins.
            if (!done_seen) begin
              tmo_hit_q     <= 1'b1;
              timeout_err_q <= 1'b1;
            end
`endif
          end
        end
        StHold: begin
          state_q   <= StReadHi;
          dm_addr_q <= rd_addr_hi;
        end
        StReadHi: begin
          state_q   <= StReadLo;
          hi_q      <= (prog_q == 2'd0) ? dm_rd_data : 8'd0;
          dm_addr_q <= rd_addr_lo;
        end
        StReadLo: begin
          state_q        <= StReport;
          result_valid_q <= 1'b1;
          result_prog_q  <= prog_q;
          result_data_q  <= report_dead ? 16'hDEAD : {hi_q, dm_rd_data};
        end
        StReport: begin
`ifdef PROG_SEQ_TIMEOUT_EN
          tmo_hit_q <= 1'b0;
`endif
          if (prog_q == 2'd2) begin
            state_q    <= StFinish;
            all_done_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            state_q <= StLoad;
            prog_q  <= prog_q + 2'd1;
          end
        end
        StFinish: begin
          state_q      <= StIdle;
          core_reset_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_reset   = core_reset_q;
  assign dm_wr_en     = dm_wr_en_q;
  assign dm_addr      = dm_addr_q;
  assign dm_wr_data   = dm_wr_data_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_prog  = result_prog_q;
  assign result_data  = result_data_q;
  assign all_done     = all_done_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: memory + core model, scoreboard of
// expected memory writes, load burst lengths and reported results.
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        core_reset;
  logic        core_done;
  logic [7:0]  dm_addr;
  logic        dm_wr_en;
  logic [7:0]  dm_wr_data;
  logic [7:0]  dm_rd_data;
  logic        busy;
  logic        result_valid;
  logic [1:0]  result_prog;
  logic [15:0] result_data;
  logic        all_done;
  logic        timeout_err;

  always #5 clk = ~clk;

`ifdef PROG_SEQ_TIMEOUT_EN
  prog_sequencer #(.TIMEOUT_CYC(20'd50)) dut (
`else
  prog_sequencer dut (
`endif
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .core_reset   (core_reset),
    .core_done    (core_done),
    .dm_addr      (dm_addr),
    .dm_wr_en     (dm_wr_en),
    .dm_wr_data   (dm_wr_data),
    .dm_rd_data   (dm_rd_data),
    .busy         (busy),
    .result_valid (result_valid),
    .result_prog  (result_prog),
    .result_data  (result_data),
    .all_done     (all_done),
    .timeout_err  (timeout_err)
  );

  // Memory and core model. core_mode: 0 = done 10 cycles after release,
  // 1 = done held high permanently, 2 = never done.
  logic [7:0] mem [256];
  logic [7:0] rel_cnt;
  int         core_mode;
  logic [7:0] c_hi0, c_lo0, c_r1, c_r2;

  assign dm_rd_data = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_wr_en) mem[dm_addr] <= dm_wr_data;
    if (core_reset) begin
      rel_cnt   <= 8'd0;
      core_done <= (core_mode == 1);
    end else begin
      rel_cnt   <= rel_cnt + 8'd1;
      mem[8'd4]   <= c_hi0;
      mem[8'd5]   <= c_lo0;
      mem[8'd7]   <= c_r1;
      mem[8'd127] <= c_r2;
      if (core_mode == 1 || (core_mode == 0 && rel_cnt == 8'd9)) core_done <= 1'b1;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_wr[$];
  logic [17:0] exp_res[$];
  int          exp_runs[$];
  logic [7:0]  lfsr_m;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic push_run(input bit dead);
    exp_wr.push_back({8'd1, 8'd5});
    exp_wr.push_back({8'd2, 8'd15});
    exp_wr.push_back({8'd3, 8'd2});
    exp_wr.push_back({8'd6, 8'h0D});
    for (int i = 0; i < 64; i++) begin
      exp_wr.push_back({8'(32 + i), lfsr_m});
      lfsr_m = lfsr_step(lfsr_m);
    end
    for (int i = 0; i < 20; i++) begin
      exp_wr.push_back({8'(128 + i), lfsr_m});
      lfsr_m = lfsr_step(lfsr_m);
    end
    exp_runs.push_back(3);
    exp_runs.push_back(65);
    exp_runs.push_back(20);
    exp_res.push_back({2'd0, dead ? 16'hDEAD : {c_hi0, c_lo0}});
    exp_res.push_back({2'd1, dead ? 16'hDEAD : {8'd0, c_r1}});
    exp_res.push_back({2'd2, dead ? 16'hDEAD : {8'd0, c_r2}});
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    int          cur_run;
    logic [15:0] w;
    logic [17:0] r;
    cur_run = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cur_run = 0;
      end else begin
        if (dm_wr_en) begin
          cur_run++;
          if (exp_wr.size() == 0) begin
            check_val("wr_unexpected", {24'd0, dm_addr}, 32'hFFFF_FFFF);
          end else begin
            w = exp_wr.pop_front();
            check_val("wr_addr", 32'(dm_addr), 32'(w[15:8]));
            check_val("wr_data", 32'(dm_wr_data), 32'(w[7:0]));
          end
        end else if (cur_run != 0) begin
          if (exp_runs.size() == 0) check_val("burst_unexpected", 32'(cur_run), 32'hFFFF_FFFF);
          else check_val("burst_len", 32'(cur_run), 32'(exp_runs.pop_front()));
          cur_run = 0;
        end
        if (result_valid) begin
          if (exp_res.size() == 0) begin
            check_val("res_unexpected", 32'(result_data), 32'hFFFF_FFFF);
          end else begin
            r = exp_res.pop_front();
            check_val("res_prog", 32'(result_prog), 32'(r[17:16]));
            check_val("res_data", 32'(result_data), 32'(r[15:0]));
          end
        end
      end
    end
  end

  // Pulse start, measure start->first result latency and released cycles
  // before it, pulse start again mid-run, wait for the sequence to finish.
  task automatic do_run(output int lat, output int low);
    bit got, fin;
    lat = 0; low = 0; got = 0; fin = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        check_val("start_busy", 32'(busy), 32'd1);
        check_val("start_clr_all_done", 32'(all_done), 32'd0);
      end
      if (n == 30) start = 1'b1;
      if (n == 31) start = 1'b0;
      if (!got) begin
        if (!core_reset) low++;
        if (result_valid) begin
          got = 1;
          lat = n;
        end
      end
      if (all_done && !busy) begin
        fin = 1;
        break;
      end
    end
    start = 1'b0;
    check_val("run_finished", 32'(fin), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired want finished");
    $fatal(1);
  end

  initial begin
    int lat, low;
    bit found;
    reset = 1'b0; start = 1'b0; core_mode = 0;
    c_hi0 = 8'h00; c_lo0 = 8'h96; c_r1 = 8'd9; c_r2 = 8'd3;
    lfsr_m = 8'h17;
    repeat (3) @(negedge clk);
    check_val("rst_core_reset", 32'(core_reset), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_wr_en", 32'(dm_wr_en), 32'd0);
    check_val("rst_addr", 32'(dm_addr), 32'd0);
    check_val("rst_wr_data", 32'(dm_wr_data), 32'd0);
    check_val("rst_valid", 32'(result_valid), 32'd0);
    check_val("rst_prog", 32'(result_prog), 32'd0);
    check_val("rst_data", 32'(result_data), 32'd0);
    check_val("rst_all_done", 32'(all_done), 32'd0);
    check_val("rst_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b1;

    // Run 1: done 10 cycles after release.
    push_run(1'b0);
    do_run(lat, low);
    check_val("run1_latency", 32'(lat), 32'd18);
    check_val("run1_released", 32'(low), 32'd11);
    check_val("run1_all_done", 32'(all_done), 32'd1);
    check_val("run1_busy", 32'(busy), 32'd0);
    check_val("run1_core_reset", 32'(core_reset), 32'd1);
    check_val("run1_timeout", 32'(timeout_err), 32'd0);
    check_val("run1_hold_prog", 32'(result_prog), 32'd2);
    check_val("run1_hold_data", 32'(result_data), 32'h0003);
    check_val("run1_wr_left", 32'(exp_wr.size()), 32'd0);
    check_val("run1_res_left", 32'(exp_res.size()), 32'd0);
    check_val("run1_burst_left", 32'(exp_runs.size()), 32'd0);

    // Run 2: done held high, stale done masked in the first WAIT cycle.
    core_mode = 1;
    c_hi0 = 8'h12; c_lo0 = 8'h34; c_r1 = 8'h55; c_r2 = 8'hA0;
    push_run(1'b0);
    do_run(lat, low);
    check_val("run2_latency", 32'(lat), 32'd10);
    check_val("run2_released", 32'(low), 32'd3);

    // Reset during prog1 LOAD at addr 50.
    core_mode = 0;
    c_hi0 = 8'h01; c_lo0 = 8'h02; c_r1 = 8'h0C; c_r2 = 8'h07;
    push_run(1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int n = 0; n < 300; n++) begin
      if (dm_wr_en && dm_addr == 8'd50) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_val("hit_addr50", 32'(found), 32'd1);
    #1 reset = 1'b0;
    #1;
    check_val("midrst_core_reset", 32'(core_reset), 32'd1);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_wr_en", 32'(dm_wr_en), 32'd0);
    check_val("midrst_addr", 32'(dm_addr), 32'd0);
    exp_wr.delete();
    exp_res.delete();
    exp_runs.delete();
    lfsr_m = 8'h17;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    push_run(1'b0);
    do_run(lat, low);
    check_val("run3_latency", 32'(lat), 32'd18);
    check_val("run3_res_left", 32'(exp_res.size()), 32'd0);

`ifdef PROG_SEQ_TIMEOUT_EN
    // Core never done: every program times out after 50 WAIT cycles.
    core_mode = 2;
    push_run(1'b1);
    do_run(lat, low);
    check_val("tmo_latency", 32'(lat), 32'd58);
    check_val("tmo_err", 32'(timeout_err), 32'd1);
    check_val("tmo_res_left", 32'(exp_res.size()), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
